// File: rtl/game_pkg.sv
// Shared game constants: colours, screen bounds and the chip drawer state encoding.
package game_pkg;

  localparam int unsigned COL_W   = 3;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned CNT_W   = 4;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  localparam logic [2:0] BG_COLOUR = COL_BLACK;

  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

endpackage

// File: rtl/rect_scanner.sv
// Row-major SIZE x SIZE scan counter; cx is the inner loop, cy the outer loop.
module rect_scanner #(
  parameter int unsigned SIZE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  output logic [3:0] cx,
  output logic [3:0] cy,
  output logic       last_c
);
  import game_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

  assign last_c = (cx == LAST_IDX) && (cy == LAST_IDX);

  // Advance one pixel per enabled cycle and wrap to 0,0 after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == LAST_IDX) begin
        cx <= '0;
        cy <= (cy == LAST_IDX) ? '0 : cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/chip_drawer.sv
// Erases the previous chip square with the background colour, then draws the
// new one, emitting one clipped pixel per clock to the VGA print stage.
module chip_drawer #(
  parameter int unsigned SIZE      = 4,
  parameter logic [2:0]  BG_COLOUR = game_pkg::BG_COLOUR,
  parameter int unsigned X_MAX     = game_pkg::X_MAX,
  parameter int unsigned Y_MAX     = game_pkg::Y_MAX
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       go,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  import game_pkg::*;

  localparam int unsigned SUM_W = COORD_W + 1;

  draw_state_t state, state_nxt;

  logic [COORD_W-1:0] new_x, new_y, prev_x, prev_y;
  logic [COL_W-1:0]   new_col;
  logic               has_prev;

  logic [CNT_W-1:0]   cx, cy;
  logic               scan_start, scan_en, scan_last_c;

  logic               go_accept;
  logic               pix_active;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COL_W-1:0]   pix_col;
  logic [SUM_W-1:0]   sum_x, sum_y;
  logic               in_bounds;

  rect_scanner #(
    .SIZE (SIZE)
  ) u_scan (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .start  (scan_start),
    .en     (scan_en),
    .cx     (cx),
    .cy     (cy),
    .last_c (scan_last_c)
  );

  // Pixel address is computed one bit wider so off-screen pixels clip instead of wrapping.
  assign sum_x     = SUM_W'(base_x) + SUM_W'(cx);
  assign sum_y     = SUM_W'(base_y) + SUM_W'(cy);
  assign in_bounds = (sum_x <= SUM_W'(X_MAX)) && (sum_y <= SUM_W'(Y_MAX));

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and per-state pixel source selection.
  always_comb begin
    state_nxt  = state;
    go_accept  = 1'b0;
    scan_start = 1'b0;
    scan_en    = 1'b0;
    pix_active = 1'b0;
    base_x     = new_x;
    base_y     = new_y;
    pix_col    = new_col;
    case (state)
      IDLE: begin
        if (go) begin
          go_accept  = 1'b1;
          scan_start = 1'b1;
          state_nxt  = has_prev ? ERASE : DRAW;
        end
      end
      ERASE: begin
        scan_en    = 1'b1;
        pix_active = 1'b1;
        base_x     = prev_x;
        base_y     = prev_y;
        pix_col    = BG_COLOUR;
        if (scan_last_c) state_nxt = DRAW;
      end
      DRAW: begin
        scan_en    = 1'b1;
        pix_active = 1'b1;
        if (scan_last_c) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs, request latches and the remembered chip position.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      plot     <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      new_x    <= '0;
      new_y    <= '0;
      new_col  <= '0;
      prev_x   <= '0;
      prev_y   <= '0;
      has_prev <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == DONE);
      plot <= pix_active && in_bounds;
      if (pix_active) begin
        x      <= sum_x[COORD_W-1:0];
        y      <= sum_y[COORD_W-1:0];
        colour <= pix_col;
      end
      if (go_accept) begin
        new_x   <= x_in;
        new_y   <= y_in;
        new_col <= colour_in;
      end
      if ((state == DRAW) && scan_last_c) begin
        prev_x   <= new_x;
        prev_y   <= new_y;
        has_prev <= 1'b1;
      end
    end
  end

endmodule
